udma_i2c_xfer_sched: RTL and testbench



---
 rtl/udma_i2c_xfer_sched.sv | 256 +++++++++++++++++++++++++
 tb/tb_udma_i2c_xfer_sched.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_i2c_xfer_sched.sv
// udma_i2c_xfer_sched: descriptor FIFO plus a sequencer that programs,
// polls and recovers the uDMA I2C channel over its config register bus.
module udma_i2c_xfer_sched #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int DEPTH          = 4,
  parameter int MAX_RETRY      = 3
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      desc_valid_i,
  output logic                      desc_ready_o,
  input  logic [L2_AWIDTH_NOAL-1:0] desc_tx_addr_i,
  input  logic [TRANS_SIZE-1:0]     desc_tx_size_i,
  input  logic [L2_AWIDTH_NOAL-1:0] desc_rx_addr_i,
  input  logic [TRANS_SIZE-1:0]     desc_rx_size_i,
  input  logic                      abort_i,
  output logic [4:0]                cfg_addr_o,
  output logic [31:0]               cfg_data_o,
  output logic                      cfg_valid_o,
  output logic                      cfg_rwn_o,
  input  logic [31:0]               cfg_data_i,
  input  logic                      cfg_ready_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [1:0]                err_code_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

  localparam logic [4:0] R_RX_SADDR = 5'd0;
  localparam logic [4:0] R_RX_SIZE  = 5'd1;
  localparam logic [4:0] R_RX_CFG   = 5'd2;
  localparam logic [4:0] R_TX_SADDR = 5'd4;
  localparam logic [4:0] R_TX_SIZE  = 5'd5;
  localparam logic [4:0] R_TX_CFG   = 5'd6;
  localparam logic [4:0] R_STATUS   = 5'd8;
  localparam logic [4:0] R_SETUP    = 5'd9;

  typedef enum logic [2:0] {
    IDLE, PROG, POLL, RESET, DONE
  } state_t;

  typedef struct packed {
    logic [L2_AWIDTH_NOAL-1:0] tx_addr;
    logic [TRANS_SIZE-1:0]     tx_size;
    logic [L2_AWIDTH_NOAL-1:0] rx_addr;
    logic [TRANS_SIZE-1:0]     rx_size;
  } desc_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        rwn;
  } acc_t;

  // Bus access for step k of state s; PROG steps 0-2 are the RX arm,
  // 3-5 the TX arm, so an RX-less descriptor simply starts at step 3.
  function automatic acc_t acc(
    input state_t s, input logic [2:0] k, input desc_t d
  );
    acc_t a;
    a = '0;
    a.rwn = (s == POLL);
    unique case (1'b1)
      (s == PROG  && k == 3'd0): begin
        a.addr = R_RX_SADDR; a.data = 32'(d.rx_addr);
      end
      (s == PROG  && k == 3'd1): begin
        a.addr = R_RX_SIZE; a.data = 32'(d.rx_size);
      end
      (s == PROG  && k == 3'd2): begin
        a.addr = R_RX_CFG; a.data = 32'h10;
      end
      (s == PROG  && k == 3'd3): begin
        a.addr = R_TX_SADDR; a.data = 32'(d.tx_addr);
      end
      (s == PROG  && k == 3'd4): begin
        a.addr = R_TX_SIZE; a.data = 32'(d.tx_size);
      end
      (s == PROG  && k == 3'd5): begin
        a.addr = R_TX_CFG; a.data = 32'h10;
      end
      (s == POLL  && k == 3'd0): a.addr = R_TX_CFG;
      (s == POLL  && k == 3'd1): a.addr = R_RX_CFG;
      (s == POLL  && k == 3'd2): a.addr = R_STATUS;
      (s == RESET && k == 3'd0): begin
        a.addr = R_SETUP; a.data = 32'h1;
      end
      (s == RESET && k == 3'd1): a.addr = R_SETUP;
      (s == RESET && k == 3'd2): begin
        a.addr = R_TX_CFG; a.data = 32'h20;
      end
      (s == RESET && k == 3'd3): begin
        a.addr = R_RX_CFG; a.data = 32'h20;
      end
      default: a = '0;
    endcase
    return a;
  endfunction

  desc_t          mem [DEPTH];
  logic [AW:0]    wptr, rptr;
  desc_t          head, din, wk;
  state_t         st;
  logic [2:0]     k, k_inc, k_poll, k_prog;
  logic [RW-1:0]  retry;
  logic           abort_q, pend;
  acc_t           req;
  logic           fire, abort_any, empty, full;
  logic           push, pop, flush, head_rx_zero;
  logic           unused_rdata;

  assign din = '{desc_tx_addr_i, desc_tx_size_i,
                 desc_rx_addr_i, desc_rx_size_i};
  assign head = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full = (wptr[AW] != rptr[AW]) &&
                (wptr[AW-1:0] == rptr[AW-1:0]);
  assign fire = cfg_valid_o & cfg_ready_i;
  assign abort_any = abort_q | abort_i;
  assign pop = (st == IDLE) && !abort_any && !empty;
  assign desc_ready_o = !full || pop;
  assign push = desc_valid_i && desc_ready_o;
  assign flush = abort_any && ((st == IDLE) ||
                 (fire && (st == PROG || st == POLL)) ||
                 (fire && st == RESET && k == 3'd3));
  assign head_rx_zero = (head.rx_size == '0);
  assign k_inc = k + 3'd1;
  assign k_poll = (k == 3'd0 && wk.rx_size == '0) ? 3'd2 : k_inc;
  assign k_prog = (wk.rx_size == '0) ? 3'd3 : 3'd0;
  assign busy_o = (st != IDLE);
  assign cfg_addr_o = req.addr;
  assign cfg_data_o = req.data;
  assign cfg_rwn_o = req.rwn;
  assign unused_rdata = ^cfg_data_i[31:6] ^ ^cfg_data_i[3:2];

  // Descriptor storage; written on an accepted push.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  // FIFO pointers; a flush also discards a push made the same cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (flush) rptr <= wptr + (AW+1)'(push);
      else if (pop) rptr <= rptr + 1'b1;
    end
  end

  // Sequencer: each accepted access selects the next one, so the
  // request register and valid change only on valid&ready.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      st <= IDLE;
      k <= '0;
      retry <= '0;
      abort_q <= 1'b0;
      pend <= 1'b0;
      wk <= '0;
      req <= '0;
      cfg_valid_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      err_code_o <= 2'b00;
    end else begin
      done_o <= 1'b0;
      err_o <= 1'b0;
      err_code_o <= 2'b00;
      if (abort_i) abort_q <= 1'b1;
      unique case (st)
        IDLE: begin
          if (abort_any) begin
            abort_q <= 1'b0;
          end else if (!empty) begin
            wk <= head;
            retry <= '0;
            st <= PROG;
            k <= head_rx_zero ? 3'd3 : 3'd0;
            req <= acc(PROG, head_rx_zero ? 3'd3 : 3'd0, head);
            cfg_valid_o <= 1'b1;
          end
        end
        PROG: if (fire) begin
          if (abort_any) begin
            st <= RESET;
            k <= 3'd0;
            req <= acc(RESET, 3'd0, wk);
          end else if (k == 3'd5) begin
            st <= POLL;
            k <= 3'd0;
            pend <= 1'b0;
            req <= acc(POLL, 3'd0, wk);
          end else begin
            k <= k_inc;
            req <= acc(PROG, k_inc, wk);
          end
        end
        POLL: if (fire) begin
          if (k != 3'd2 && cfg_data_i[5:4] != 2'b00) pend <= 1'b1;
          if (abort_any || (k == 3'd2 && cfg_data_i[1])) begin
            st <= RESET;
            k <= 3'd0;
            req <= acc(RESET, 3'd0, wk);
          end else if (k != 3'd2) begin
            k <= k_poll;
            req <= acc(POLL, k_poll, wk);
          end else if (!pend && !cfg_data_i[0]) begin
            st <= DONE;
            cfg_valid_o <= 1'b0;
            req <= '0;
            done_o <= 1'b1;
          end else begin
            k <= 3'd0;
            pend <= 1'b0;
            req <= acc(POLL, 3'd0, wk);
          end
        end
        RESET: if (fire) begin
          if (k != 3'd3) begin
            k <= k_inc;
            req <= acc(RESET, k_inc, wk);
          end else if (abort_any) begin
            st <= IDLE;
            cfg_valid_o <= 1'b0;
            req <= '0;
            abort_q <= 1'b0;
            err_o <= 1'b1;
            err_code_o <= 2'b10;
          end else if (retry < MAX_R) begin
            retry <= retry + RW'(1);
            st <= PROG;
            k <= k_prog;
            req <= acc(PROG, k_prog, wk);
          end else begin
            st <= IDLE;
            cfg_valid_o <= 1'b0;
            req <= '0;
            err_o <= 1'b1;
            err_code_o <= 2'b01;
          end
        end
        DONE: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udma_i2c_xfer_sched.sv
// tb_udma_i2c_xfer_sched: directed steps with an access scoreboard and
// a register-bus responder that models channel CFG/STATUS behaviour.
module tb_udma_i2c_xfer_sched;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        desc_valid_i;
  logic        desc_ready_o;
  logic [11:0] desc_tx_addr_i;
  logic [15:0] desc_tx_size_i;
  logic [11:0] desc_rx_addr_i;
  logic [15:0] desc_rx_size_i;
  logic        abort_i;
  logic [4:0]  cfg_addr_o;
  logic [31:0] cfg_data_o;
  logic        cfg_valid_o;
  logic        cfg_rwn_o;
  logic [31:0] cfg_data_i;
  logic        cfg_ready_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  udma_i2c_xfer_sched dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
    .desc_tx_addr_i(desc_tx_addr_i), .desc_tx_size_i(desc_tx_size_i),
    .desc_rx_addr_i(desc_rx_addr_i), .desc_rx_size_i(desc_rx_size_i),
    .abort_i(abort_i),
    .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o),
    .cfg_valid_o(cfg_valid_o), .cfg_rwn_o(cfg_rwn_o),
    .cfg_data_i(cfg_data_i), .cfg_ready_i(cfg_ready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .err_code_o(err_code_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        rwn;
  } acc_t;

  acc_t exp_q[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  logic [1:0] last_code = 2'b00;
  int   rounds_cfg = 3;
  int   rounds_left = 0;
  bit   al_mode = 1'b0;
  int   stall_left = 0;
  bit   snapped = 1'b0;
  acc_t snap;
  bit   prev_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic acc_t mk(input logic [4:0] a, input logic [31:0] d,
                              input logic r);
    acc_t x;
    x.addr = a;
    x.data = d;
    x.rwn = r;
    return x;
  endfunction

  task automatic exp_prog(input logic [11:0] ta, input logic [15:0] ts,
                          input logic [11:0] ra, input logic [15:0] rs);
    if (rs != 16'd0) begin
      exp_q.push_back(mk(5'd0, {20'd0, ra}, 1'b0));
      exp_q.push_back(mk(5'd1, {16'd0, rs}, 1'b0));
      exp_q.push_back(mk(5'd2, 32'h10, 1'b0));
    end
    exp_q.push_back(mk(5'd4, {20'd0, ta}, 1'b0));
    exp_q.push_back(mk(5'd5, {16'd0, ts}, 1'b0));
    exp_q.push_back(mk(5'd6, 32'h10, 1'b0));
  endtask

  task automatic exp_round(input bit rx_nz);
    exp_q.push_back(mk(5'd6, 32'h0, 1'b1));
    if (rx_nz) exp_q.push_back(mk(5'd2, 32'h0, 1'b1));
    exp_q.push_back(mk(5'd8, 32'h0, 1'b1));
  endtask

  task automatic exp_reset();
    exp_q.push_back(mk(5'd9, 32'h1, 1'b0));
    exp_q.push_back(mk(5'd9, 32'h0, 1'b0));
    exp_q.push_back(mk(5'd6, 32'h20, 1'b0));
    exp_q.push_back(mk(5'd2, 32'h20, 1'b0));
  endtask

  // kind: 0 normal completion, 1 arbitration loss every round,
  // 2 program plus one round (abort follows), 3 never executed
  task automatic push_desc(input logic [11:0] ta, input logic [15:0] ts,
                           input logic [11:0] ra, input logic [15:0] rs,
                           input int kind, output int waited);
    waited = 0;
    @(negedge clk_i);
    desc_valid_i = 1'b1;
    desc_tx_addr_i = ta;
    desc_tx_size_i = ts;
    desc_rx_addr_i = ra;
    desc_rx_size_i = rs;
    while (!desc_ready_o && waited < 2000) begin
      @(negedge clk_i);
      waited++;
    end
    check("push_accept", desc_ready_o, 1);
    if (desc_ready_o) begin
      if (kind == 0) begin
        exp_prog(ta, ts, ra, rs);
        for (int r = 0; r < rounds_cfg; r++) exp_round(rs != 0);
      end else if (kind == 1) begin
        for (int a = 0; a < 4; a++) begin
          exp_prog(ta, ts, ra, rs);
          exp_round(rs != 0);
          exp_reset();
        end
      end else if (kind == 2) begin
        exp_prog(ta, ts, ra, rs);
        exp_round(rs != 0);
      end
    end
    @(posedge clk_i);
    #1;
    desc_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int c = 0; c < 3000 && done_cnt < target; c++)
      @(negedge clk_i);
    check(tag, done_cnt, target);
  endtask

  task automatic wait_err(input int target, input string tag);
    for (int c = 0; c < 3000 && err_cnt < target; c++)
      @(negedge clk_i);
    check(tag, err_cnt, target);
  endtask

  // Monitor and responder: sample away from the active edge, choose
  // ready/read data for the next edge, score accepted accesses.
  always @(negedge clk_i) begin : mon
    acc_t cur;
    acc_t e;
    if (rstn_i) begin
      cur = {cfg_addr_o, cfg_data_o, cfg_rwn_o};
      if (prev_done) begin
        check("done_width", done_o, 0);
        check("busy_after_done", busy_o, 0);
      end
      prev_done = done_o;
      if (done_o) begin
        done_cnt++;
        check("busy_in_done", busy_o, 1);
      end
      if (err_o) begin
        err_cnt++;
        last_code = err_code_o;
      end
      if (done_o || err_o) check("done_err_excl", done_o & err_o, 0);
      if (cfg_valid_o && !cur.rwn && cur.addr == 5'd5 && stall_left > 0)
      begin
        if (!snapped) begin
          snap = cur;
          snapped = 1'b1;
        end else begin
          check("stall_hold", cur, snap);
        end
        stall_left--;
        cfg_ready_i = 1'b0;
      end else begin
        if (snapped) begin
          check("stall_valid", cfg_valid_o, 1);
          check("stall_hold", cur, snap);
          snapped = 1'b0;
        end
        cfg_ready_i = 1'b1;
      end
      if (cfg_valid_o && cfg_ready_i) begin
        if (exp_q.size() == 0) begin
          check("spurious_access", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("access", cur, e);
        end
        if (cur.rwn) begin
          if (cur.addr == 5'd8) begin
            cfg_data_i = al_mode ? 32'h2 :
                         (rounds_left > 1 ? 32'h1 : 32'h0);
            rounds_left--;
          end else begin
            cfg_data_i = (al_mode || rounds_left > 1) ? 32'h10 : 32'h0;
          end
        end else if (cur.addr == 5'd6 && cur.data == 32'h10) begin
          rounds_left = rounds_cfg;
        end
      end
    end
  end

  initial begin
    int w;
    int d0;
    int e0;
    desc_valid_i = 1'b0;
    desc_tx_addr_i = '0;
    desc_tx_size_i = '0;
    desc_rx_addr_i = '0;
    desc_rx_size_i = '0;
    abort_i = 1'b0;
    cfg_data_i = '0;
    cfg_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_ready", desc_ready_o, 1);
    check("rst_valid", cfg_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_code", err_code_o, 0);
    check("rst_addr", cfg_addr_o, 0);
    check("rst_data", cfg_data_o, 0);
    check("rst_rwn", cfg_rwn_o, 0);
    rstn_i = 1'b1;

    // single descriptor, done on the third poll round
    rounds_cfg = 3;
    push_desc(12'h100, 16'd8, 12'h200, 16'd4, 0, w);
    wait_done(1, "t1_done");
    check("t1_err", err_cnt, 0);
    check("t1_exp_empty", exp_q.size(), 0);

    // no RX phase
    rounds_cfg = 2;
    push_desc(12'h300, 16'd3, 12'h000, 16'd0, 0, w);
    wait_done(2, "t2_done");
    check("t2_exp_empty", exp_q.size(), 0);

    // arbitration lost on every attempt
    al_mode = 1'b1;
    push_desc(12'h040, 16'd2, 12'h080, 16'd1, 1, w);
    wait_err(1, "t3_err");
    check("t3_code", last_code, 2'b01);
    check("t3_no_done", done_cnt, 2);
    check("t3_exp_empty", exp_q.size(), 0);
    al_mode = 1'b0;

    // stalled TX_SIZE write
    rounds_cfg = 1;
    stall_left = 5;
    push_desc(12'h123, 16'd9, 12'h321, 16'd7, 0, w);
    wait_done(3, "t4_done");
    check("t4_stalls_used", stall_left, 0);
    check("t4_exp_empty", exp_q.size(), 0);

    // FIFO fill while busy
    rounds_cfg = 3;
    d0 = done_cnt;
    push_desc(12'h500, 16'd5, 12'h600, 16'd2, 0, w);
    for (int i = 0; i < 4; i++)
      push_desc(12'h510 + 12'(i), 16'd1 + 16'(i), 12'h610 + 12'(i),
                16'd1, 0, w);
    check("t5_full", desc_ready_o, 0);
    push_desc(12'h520, 16'd6, 12'h000, 16'd0, 0, w);
    check("t5_push_stalled", w > 0, 1);
    check("t5_pop_first", done_cnt - d0, 1);
    wait_done(d0 + 6, "t5_done");
    check("t5_exp_empty", exp_q.size(), 0);

    // abort during polling with two descriptors queued
    rounds_cfg = 1000;
    e0 = err_cnt;
    d0 = done_cnt;
    push_desc(12'h700, 16'd4, 12'h780, 16'd4, 2, w);
    push_desc(12'h710, 16'd1, 12'h790, 16'd1, 3, w);
    push_desc(12'h720, 16'd1, 12'h7a0, 16'd1, 3, w);
    for (int c = 0; c < 200 && exp_q.size() != 0; c++)
      @(posedge clk_i);
    check("t6_sync", exp_q.size(), 0);
    #1;
    abort_i = 1'b1;
    exp_q.push_back(mk(5'd6, 32'h0, 1'b1));
    exp_reset();
    @(posedge clk_i);
    #1;
    abort_i = 1'b0;
    wait_err(e0 + 1, "t6_err");
    check("t6_code", last_code, 2'b10);
    repeat (5) @(negedge clk_i);
    check("t6_idle", busy_o, 0);
    check("t6_fifo_empty", desc_ready_o, 1);
    check("t6_no_done", done_cnt, d0);
    check("t6_exp_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
